// File: rtl/config_bus_master.sv
// ---------------------------------------------------------------------------
// config_bus_master
//
// Upstream driver for a tile core's configuration port. Requests arrive on a
// valid/ready interface, are sequenced onto the core's config pins (address,
// data, read strobe, write strobe), and a response is returned on a second
// valid/ready interface. Only one transaction is in flight at a time.
//
// Optional feature, enabled by defining CFG_READBACK_VERIFY_EN:
//   every write is followed by a readback of the same address. The captured
//   value becomes resp_data, and resp_err flags a mismatch against the
//   written data. Without the macro, resp_err is tied low and no comparator
//   is built.
//
// Parameters:
//   ADDR_WIDTH   - config address width
//   DATA_WIDTH   - config data width
//   READ_LATENCY - cycles cfg_read is held before read data is sampled (1..15)
//   CNT_WIDTH    - width of the completed-transaction counter
//
// Ports:
//   real_clk, real_rst      clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write               1 = write, 0 = read
//   req_addr, req_data      request address / write data
//   cfg_addr, cfg_data      to core config_config_addr / config_config_data
//   cfg_read, cfg_write     to core config_read / config_write
//   cfg_rdata               from core read_config_data
//   resp_valid/resp_ready   response handshake
//   resp_data               read data (0 for plain writes)
//   resp_err                readback mismatch flag
//   txn_count               completed transactions, wraps to 0
// ---------------------------------------------------------------------------
module config_bus_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  real_clk,
    input  logic                  real_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_read,
    output logic                  cfg_write,
    input  logic [DATA_WIDTH-1:0] cfg_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  txn_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } state_t;

    // READ_LATENCY is limited to 1..15, so a 4-bit wait counter suffices.
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY);

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_next;
    logic                  last_wait;
    logic [ADDR_WIDTH-1:0] cfg_addr_next;
    logic [DATA_WIDTH-1:0] cfg_data_next;
    logic                  cfg_read_next;
    logic                  cfg_write_next;
    logic                  resp_valid_next;
    logic [DATA_WIDTH-1:0] resp_data_next;
    logic [CNT_WIDTH-1:0]  txn_count_next;

`ifdef CFG_READBACK_VERIFY_EN
    // Remembers whether the readback in progress belongs to a write, so only
    // write readbacks can raise resp_err.
    logic txn_write;
    logic txn_write_next;
    logic resp_err_next;
`endif

    assign req_ready = (state == IDLE);
    assign last_wait = (wait_cnt == 4'd1);

    // State register.
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_write ? WRITE : READ_WAIT;
                end
            end
            WRITE: begin
`ifdef CFG_READBACK_VERIFY_EN
                state_next = READ_WAIT;
`else
                state_next = RESP;
`endif
            end
            READ_WAIT: begin
                if (last_wait) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs. The strobes default low so each
    // is high only for the cycles its state explicitly requests; the address,
    // data and response fields default to holding.
    always_comb begin
        cfg_addr_next   = cfg_addr;
        cfg_data_next   = cfg_data;
        cfg_read_next   = 1'b0;
        cfg_write_next  = 1'b0;
        resp_valid_next = resp_valid;
        resp_data_next  = resp_data;
        txn_count_next  = txn_count;
        wait_cnt_next   = wait_cnt;
`ifdef CFG_READBACK_VERIFY_EN
        txn_write_next  = txn_write;
        resp_err_next   = resp_err;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cfg_addr_next = req_addr;
                    cfg_data_next = req_data;
`ifdef CFG_READBACK_VERIFY_EN
                    txn_write_next = req_write;
                    resp_err_next  = 1'b0;
`endif
                    if (req_write) begin
                        cfg_write_next = 1'b1;
                    end else begin
                        cfg_read_next = 1'b1;
                        wait_cnt_next = LAT_LOAD;
                    end
                end
            end
            WRITE: begin
`ifdef CFG_READBACK_VERIFY_EN
                cfg_read_next = 1'b1;
                wait_cnt_next = LAT_LOAD;
`else
                resp_valid_next = 1'b1;
                resp_data_next  = '0;
`endif
            end
            READ_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (last_wait) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = cfg_rdata;
`ifdef CFG_READBACK_VERIFY_EN
                    // cfg_data still holds the written value during readback.
                    resp_err_next = txn_write && (cfg_rdata != cfg_data);
`endif
                end else begin
                    cfg_read_next = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_next = 1'b0;
                    txn_count_next  = txn_count + CNT_WIDTH'(1);
                end
            end
            default: begin
                resp_valid_next = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            cfg_addr   <= '0;
            cfg_data   <= '0;
            cfg_read   <= 1'b0;
            cfg_write  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            txn_count  <= '0;
            wait_cnt   <= 4'd0;
        end else begin
            cfg_addr   <= cfg_addr_next;
            cfg_data   <= cfg_data_next;
            cfg_read   <= cfg_read_next;
            cfg_write  <= cfg_write_next;
            resp_valid <= resp_valid_next;
            resp_data  <= resp_data_next;
            txn_count  <= txn_count_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

`ifdef CFG_READBACK_VERIFY_EN
    // Readback comparison state.
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            txn_write <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            txn_write <= txn_write_next;
            resp_err  <= resp_err_next;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_config_bus_master.sv
// ---------------------------------------------------------------------------
// tb_config_bus_master
//
// Directed testbench for config_bus_master with READ_LATENCY=3 and a 3-bit
// transaction counter (so counter wrap is reachable quickly). A small core
// model stores writes and returns stored data (optionally with bit 0 masked)
// while cfg_read is high. Expected responses are queued when requests are
// issued and checked by an independent monitor at each response handshake.
// ---------------------------------------------------------------------------
module tb_config_bus_master;

    localparam int LAT = 3;
`ifdef CFG_READBACK_VERIFY_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        real_clk;
    logic        real_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_read;
    logic        cfg_write;
    logic [31:0] cfg_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [2:0]  txn_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_def;
        logic [31:0] exp_rb;
        logic        err_rb;
    } vec_t;

    resp_t       sb[$];
    resp_t       mon_exp;
    vec_t        vecs[12];
    logic [31:0] mem[256];
    logic [31:0] rdata_mask;

    config_bus_master #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .READ_LATENCY(LAT),
        .CNT_WIDTH   (3)
    ) dut (
        .real_clk  (real_clk),
        .real_rst  (real_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_read  (cfg_read),
        .cfg_write (cfg_write),
        .cfg_rdata (cfg_rdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .txn_count (txn_count)
    );

    initial real_clk = 1'b0;
    always #5 real_clk = ~real_clk;

    always @(posedge real_clk) cyc <= cyc + 1;

    // Core model: stores on cfg_write, returns (masked) data while reading.
    always @(posedge real_clk) begin
        if (cfg_write) mem[cfg_addr] <= cfg_data;
    end
    assign cfg_rdata = cfg_read ? (mem[cfg_addr] & rdata_mask) : 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Response monitor: compares every handshake against the queue head.
    always @(negedge real_clk) begin
        if (!real_rst && resp_valid && resp_ready) begin
            checkOutput("sb_nonempty_at_resp", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checkOutput("resp_data", resp_data, mon_exp.data);
                checkOutput("resp_err", {31'b0, resp_err}, {31'b0, mon_exp.err});
            end
        end
    end

    // Issue one request, queue its expected response and check the pin timing
    // cycle by cycle up to the cycle resp_valid first rises.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_data,
                                 input logic exp_err, output int acc_cyc);
        int         wait_n;
        int         resp_k;
        logic [2:0] exp_pins;
        wait_n  = 0;
        acc_cyc = -1;
        while (!req_ready && wait_n < 20) begin
            @(posedge real_clk); #1;
            wait_n++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        sb.push_back('{exp_data, exp_err});
        @(posedge real_clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        resp_k    = wr ? (RB ? LAT + 2 : 2) : LAT + 1;
        for (int k = 1; k <= resp_k; k++) begin
            if (k > 1) begin
                @(posedge real_clk); #1;
            end
            exp_pins[2] = wr && (k == 1);
            exp_pins[1] = wr ? (RB && k >= 2 && k <= LAT + 1) : (k <= LAT);
            exp_pins[0] = (k == resp_k);
            checkOutput($sformatf("pins wr/rd/vld k=%0d", k),
                        {29'b0, cfg_write, cfg_read, resp_valid}, {29'b0, exp_pins});
            if (k == 1) begin
                checkOutput("cfg_addr", 32'(cfg_addr), 32'(addr));
                checkOutput("cfg_data", cfg_data, data);
            end
        end
    endtask

    task automatic runVec(input int idx, output int acc_cyc);
        applyStimulus(vecs[idx].wr, vecs[idx].addr, vecs[idx].data,
                      RB ? vecs[idx].exp_rb : vecs[idx].exp_def,
                      RB ? vecs[idx].err_rb : 1'b0, acc_cyc);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int prev_acc;

        vecs[0]  = '{1'b1, 8'h01, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 8'h01, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 8'h02, 32'h0000A5A5, 32'h0, 32'h0000A5A5, 1'b0};
        vecs[3]  = '{1'b1, 8'h03, 32'h12345678, 32'h0, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b0, 8'h02, 32'h0,        32'h0000A5A5, 32'h0000A5A5, 1'b0};
        vecs[5]  = '{1'b0, 8'h04, 32'h0,        32'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 8'h05, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b1, 8'h06, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 1'b0};
        vecs[8]  = '{1'b0, 8'h02, 32'h0,        32'h0000A5A5, 32'h0000A5A5, 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 32'h00000003, 32'h0, 32'h00000002, 1'b1};
        vecs[10] = '{1'b1, 8'h11, 32'h00000002, 32'h0, 32'h00000002, 1'b0};
        vecs[11] = '{1'b0, 8'h10, 32'h0,        32'h00000002, 32'h00000002, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rdata_mask = 32'hFFFFFFFF;

        // Reset with a write request already pending.
        real_rst   = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 8'h55;
        req_data   = 32'h12345678;
        resp_ready = 1'b1;
        repeat (3) @(posedge real_clk);
        #1;
        checkOutput("in reset wr/rd/vld", {29'b0, cfg_write, cfg_read, resp_valid}, 32'd0);
        #3 real_rst = 1'b0;
        #1;
        checkOutput("post reset cfg_addr", 32'(cfg_addr), 32'd0);
        checkOutput("post reset cfg_data", cfg_data, 32'd0);
        checkOutput("post reset rdy/wr/rd/vld/err",
                    {27'b0, req_ready, cfg_write, cfg_read, resp_valid, resp_err}, 32'h10);
        checkOutput("post reset resp_data", resp_data, 32'd0);
        checkOutput("post reset txn_count", 32'(txn_count), 32'd0);
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge real_clk); #1;
            checkOutput("idle cfg_write/req_ready", {30'b0, cfg_write, req_ready}, 32'd1);
        end

        // First write, with counter checked before and after the handshake.
        runVec(0, acc);
        checkOutput("txn before first handshake", 32'(txn_count), 32'd0);
        @(posedge real_clk); #1;
        checkOutput("txn after first write", 32'(txn_count), 32'd1);
        checkOutput("req_ready after first write", {31'b0, req_ready}, 32'd1);

        // Back-to-back traffic with resp_ready held high.
        prev_acc = acc;
        for (int i = 1; i <= 5; i++) begin
            runVec(i, acc);
            if (i == 3) begin
                checkOutput("write-to-write spacing", 32'(acc - prev_acc),
                            RB ? 32'(LAT + 3) : 32'd3);
            end
            prev_acc = acc;
        end
        @(posedge real_clk); #1;
        checkOutput("txn after burst", 32'(txn_count), 32'd6);

        // Backpressure: response held 5 cycles while a second request waits.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 8'h01, 32'h0, 32'hDEADBEEF, 1'b0, acc);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h07;
        req_data  = 32'h00000077;
        for (int i = 0; i < 5; i++) begin
            @(posedge real_clk); #1;
            checkOutput("stall resp_valid", {31'b0, resp_valid}, 32'd1);
            checkOutput("stall resp_data", resp_data, 32'hDEADBEEF);
            checkOutput("stall req_ready/cfg_write", {30'b0, req_ready, cfg_write}, 32'd0);
            checkOutput("stall cfg_addr", 32'(cfg_addr), 32'h01);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge real_clk); #1;
        checkOutput("post-stall resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("txn after stall", 32'(txn_count), 32'd7);

        // Counter wraps from all-ones.
        runVec(6, acc);
        @(posedge real_clk); #1;
        checkOutput("txn wrap", 32'(txn_count), 32'd0);
        runVec(7, acc);
        @(posedge real_clk); #1;
        checkOutput("txn after wrap", 32'(txn_count), 32'd1);

        // Reset pulse in the middle of a read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h02;
        req_data  = 32'h0;
        @(posedge real_clk); #1;
        req_valid = 1'b0;
        checkOutput("pre-reset cfg_read", {31'b0, cfg_read}, 32'd1);
        @(posedge real_clk); #1;
        checkOutput("pre-reset cfg_read 2", {31'b0, cfg_read}, 32'd1);
        #2 real_rst = 1'b1;
        #1;
        checkOutput("async reset wr/rd/vld/rdy",
                    {28'b0, cfg_write, cfg_read, resp_valid, req_ready}, 32'h1);
        checkOutput("async reset cfg_addr", 32'(cfg_addr), 32'd0);
        checkOutput("async reset txn_count", 32'(txn_count), 32'd0);
        #2 real_rst = 1'b0;
        repeat (4) begin
            @(posedge real_clk); #1;
            checkOutput("no lost response", {30'b0, resp_valid, cfg_read}, 32'd0);
        end
        runVec(8, acc);
        @(posedge real_clk); #1;
        checkOutput("txn after reset read", 32'(txn_count), 32'd1);

        // Core that drops bit 0 on readback.
        rdata_mask = 32'hFFFFFFFE;
        for (int i = 9; i <= 11; i++) runVec(i, acc);
        @(posedge real_clk); #1;
        checkOutput("txn final", 32'(txn_count), 32'd4);
        checkOutput("sb leftover", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
